// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if: signal bundle between two host ports, the arbiter and an SDRAM controller
// Host side : pN_req/pN_we/pN_addr/pN_wdata toward the arbiter, pN_ack/pN_rdata back.
// Ctl side  : ctl_rd_addr/ctl_wr_addr/ctl_wr_data/ctl_rd_enable/ctl_wr_enable toward the
//             controller, ctl_rd_data/ctl_rd_ready/ctl_busy back.
// slave  modport: the arbiter's view.
// master modport: the environment's view (requesters plus controller).
interface sdram_arbiter_if #(parameter int HADDR_WIDTH = 24);
    logic                   p0_req;
    logic                   p0_we;
    logic [HADDR_WIDTH-1:0] p0_addr;
    logic [15:0]            p0_wdata;
    logic                   p0_ack;
    logic [15:0]            p0_rdata;
    logic                   p1_req;
    logic                   p1_we;
    logic [HADDR_WIDTH-1:0] p1_addr;
    logic [15:0]            p1_wdata;
    logic                   p1_ack;
    logic [15:0]            p1_rdata;
    logic [HADDR_WIDTH-1:0] ctl_rd_addr;
    logic [HADDR_WIDTH-1:0] ctl_wr_addr;
    logic [15:0]            ctl_wr_data;
    logic                   ctl_rd_enable;
    logic                   ctl_wr_enable;
    logic [15:0]            ctl_rd_data;
    logic                   ctl_rd_ready;
    logic                   ctl_busy;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        output p0_ack, p0_rdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        output p1_ack, p1_rdata,
        output ctl_rd_addr, ctl_wr_addr, ctl_wr_data, ctl_rd_enable, ctl_wr_enable,
        input  ctl_rd_data, ctl_rd_ready, ctl_busy
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        input  p0_ack, p0_rdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        input  p1_ack, p1_rdata,
        input  ctl_rd_addr, ctl_wr_addr, ctl_wr_data, ctl_rd_enable, ctl_wr_enable,
        output ctl_rd_data, ctl_rd_ready, ctl_busy
    );
endinterface

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: two-port arbiter in front of a single-command SDRAM controller
// Ports: clk (posedge), rst (async, active-high), bus (sdram_arbiter_if.slave) carrying
//        both host request/ack ports and the controller command/status signals.
// Optional feature: define SDRAM_ARB_ROUND_ROBIN_EN for round-robin arbitration on
//        simultaneous requests; otherwise port 0 has fixed priority.
module sdram_arbiter #(
    parameter int HADDR_WIDTH = 24
) (
    input logic           clk,
    input logic           rst,
    sdram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                 state;
    logic                   we;
    logic                   grant;
    logic [HADDR_WIDTH-1:0] addr;
    logic [15:0]            wdata;
    logic                   rd_en;
    logic                   wr_en;
    logic                   ack0;
    logic                   ack1;
    logic [15:0]            rdata0;
    logic [15:0]            rdata1;
    logic                   any_req;
    logic                   win;
    logic                   sel_we;
    logic [HADDR_WIDTH-1:0] sel_addr;
    logic [15:0]            sel_wdata;

    assign any_req = bus.p0_req | bus.p1_req;

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    // ptr names the port preferred on the next conflict; a lone requester still wins.
    logic ptr;

    assign win = (bus.p0_req & bus.p1_req) ? ptr : bus.p1_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= 1'b0;
        else if (state == IDLE && any_req)
            ptr <= ~win;
    end
`else
    assign win = ~bus.p0_req;
`endif

    always_comb begin
        sel_we    = win ? bus.p1_we    : bus.p0_we;
        sel_addr  = win ? bus.p1_addr  : bus.p0_addr;
        sel_wdata = win ? bus.p1_wdata : bus.p0_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            we     <= 1'b0;
            grant  <= 1'b0;
            addr   <= '0;
            wdata  <= '0;
            rd_en  <= 1'b0;
            wr_en  <= 1'b0;
            ack0   <= 1'b0;
            ack1   <= 1'b0;
            rdata0 <= '0;
            rdata1 <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant <= win;
                        we    <= sel_we;
                        addr  <= sel_addr;
                        wdata <= sel_wdata;
                        rd_en <= ~sel_we;
                        wr_en <= sel_we;
                        state <= ISSUE;
                    end
                end
                // Busy lags the enable and refresh can stall it, so the strobe is held.
                ISSUE: begin
                    if (bus.ctl_busy) begin
                        rd_en <= 1'b0;
                        wr_en <= 1'b0;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.ctl_rd_ready && !we) begin
                        if (grant)
                            rdata1 <= bus.ctl_rd_data;
                        else
                            rdata0 <= bus.ctl_rd_data;
                    end
                    if (!bus.ctl_busy) begin
                        ack0  <= ~grant;
                        ack1  <= grant;
                        state <= DONE;
                    end
                end
                // The extra IDLE cycle after DONE keeps enables off for two cycles after busy.
                DONE: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.p0_ack        = ack0;
    assign bus.p1_ack        = ack1;
    assign bus.p0_rdata      = rdata0;
    assign bus.p1_rdata      = rdata1;
    assign bus.ctl_rd_addr   = addr;
    assign bus.ctl_wr_addr   = addr;
    assign bus.ctl_wr_data   = wdata;
    assign bus.ctl_rd_enable = rd_en;
    assign bus.ctl_wr_enable = wr_en;
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: self-checking bench for sdram_arbiter with a behavioural controller model
module tb_sdram_arbiter;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    sdram_arbiter_if #(.HADDR_WIDTH(24)) bus();

    sdram_arbiter #(.HADDR_WIDTH(24)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Controller model: accepts a held enable, raises busy lag cycles later, keeps busy
    // for blen cycles, and completes the access as busy falls.
    int         lag = 2;
    int         blen = 3;
    int         ops = 0;
    int         hold_err = 0;
    int         m_st = 0;
    int         m_cnt = 0;
    bit         m_we;
    bit [23:0]  m_addr;
    bit [15:0]  m_wd;
    bit [15:0]  cmem [bit [23:0]];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_st             <= 0;
            bus.ctl_busy     <= 1'b0;
            bus.ctl_rd_ready <= 1'b0;
            bus.ctl_rd_data  <= '0;
        end else begin
            bus.ctl_rd_ready <= 1'b0;
            if (m_st == 0) begin
                if (bus.ctl_rd_enable || bus.ctl_wr_enable) begin
                    m_we   <= bus.ctl_wr_enable;
                    m_addr <= bus.ctl_wr_enable ? bus.ctl_wr_addr : bus.ctl_rd_addr;
                    m_wd   <= bus.ctl_wr_data;
                    m_cnt  <= lag - 1;
                    m_st   <= 1;
                    ops    <= ops + 1;
                end
            end else if (m_st == 1) begin
                if (!(bus.ctl_rd_enable || bus.ctl_wr_enable))
                    hold_err <= hold_err + 1;
                if (m_cnt <= 1) begin
                    bus.ctl_busy <= 1'b1;
                    m_cnt        <= blen;
                    m_st         <= 2;
                end else
                    m_cnt <= m_cnt - 1;
            end else begin
                if (m_cnt == 1) begin
                    bus.ctl_busy <= 1'b0;
                    m_st         <= 0;
                    if (m_we)
                        cmem[m_addr] = m_wd;
                    else begin
                        bus.ctl_rd_ready <= 1'b1;
                        bus.ctl_rd_data  <= cmem.exists(m_addr) ? cmem[m_addr] : 16'h0;
                    end
                end else
                    m_cnt <= m_cnt - 1;
            end
        end
    end

    // Reference: memory contents as seen by completed writes, and each port's last read.
    bit [15:0] ref_mem [bit [23:0]];
    bit [15:0] ref_rd0 = 16'h0;
    bit [15:0] ref_rd1 = 16'h0;
    bit [23:0] addrs [4] = '{24'h000123, 24'h000456, 24'hABCDEF, 24'h000001};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit [15:0] mem_rd(input bit [23:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 16'h0;
    endfunction

    task automatic op(input bit port, input bit we, input bit [23:0] a, input bit [15:0] d,
                      input int lg, input int bl, input bit drop);
        int        cyc = 0;
        int        en_cyc = 0;
        int        extra = 0;
        int        ops0;
        bit        wrong = 0;
        bit        got0;
        bit        got1;
        bit [15:0] exp_rd;
        lag  = lg;
        blen = bl;
        ops0 = ops;
        exp_rd = we ? (port ? ref_rd1 : ref_rd0) : mem_rd(a);
        @(negedge clk);
        if (port) begin
            bus.p1_we = we; bus.p1_addr = a; bus.p1_wdata = d; bus.p1_req = 1'b1;
        end else begin
            bus.p0_we = we; bus.p0_addr = a; bus.p0_wdata = d; bus.p0_req = 1'b1;
        end
        do begin
            @(negedge clk);
            cyc++;
            if (bus.ctl_rd_enable || bus.ctl_wr_enable) en_cyc++;
            if ((bus.ctl_wr_enable && !we) || (bus.ctl_rd_enable && we)) wrong = 1'b1;
            if (drop && bus.ctl_busy && !(bus.ctl_rd_enable || bus.ctl_wr_enable)) begin
                bus.p0_req = 1'b0;
                bus.p1_req = 1'b0;
            end
        end while (!(bus.p0_ack || bus.p1_ack) && cyc < 300);
        got0 = bus.p0_ack;
        got1 = bus.p1_ack;
        bus.p0_req = 1'b0;
        bus.p1_req = 1'b0;
        chk("ack_timeout", cyc < 300, 1);
        chk("ack_p0", got0, !port);
        chk("ack_p1", got1, port);
        chk("enable_kind", wrong, 0);
        chk("rdata_own", port ? bus.p1_rdata : bus.p0_rdata, exp_rd);
        chk("rdata_other", port ? bus.p0_rdata : bus.p1_rdata, port ? ref_rd0 : ref_rd1);
        chk("ctl_rd_addr", bus.ctl_rd_addr, a);
        chk("ctl_wr_addr", bus.ctl_wr_addr, a);
        if (we) chk("ctl_wr_data", bus.ctl_wr_data, d);
        repeat (4) begin
            @(negedge clk);
            if (bus.p0_ack || bus.p1_ack) extra++;
        end
        chk("extra_ack", extra, 0);
        chk("ops_issued", ops - ops0, 1);
        if (lg > 2) chk("refresh_hold", en_cyc >= lg, 1);
        if (we) ref_mem[a] = d;
        else if (port) ref_rd1 = exp_rd;
        else ref_rd0 = exp_rd;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_p0_ack"}, bus.p0_ack, 0);
        chk({tag, "_p1_ack"}, bus.p1_ack, 0);
        chk({tag, "_rd_en"}, bus.ctl_rd_enable, 0);
        chk({tag, "_wr_en"}, bus.ctl_wr_enable, 0);
        chk({tag, "_p0_rdata"}, bus.p0_rdata, 0);
        chk({tag, "_p1_rdata"}, bus.p1_rdata, 0);
        chk({tag, "_addr"}, bus.ctl_rd_addr, 0);
        chk({tag, "_wdata"}, bus.ctl_wr_data, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int        cyc;
        int        n;
        bit        last;
        bit        exp_w;
        bit        order [4];
        bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_addr = '0; bus.p0_wdata = '0;
        bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = '0; bus.p1_wdata = '0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;

        op(1'b0, 1'b1, 24'h000123, 16'hBEEF, 2, 3, 1'b0);
        op(1'b1, 1'b0, 24'h000123, 16'h0000, 2, 4, 1'b0);
        chk("p1_read_beef", bus.p1_rdata, 16'hBEEF);
        op(1'b0, 1'b1, 24'h000456, 16'h1234, 20, 3, 1'b0);
        chk("refresh_enable_held", hold_err, 0);
        op(1'b0, 1'b0, 24'h000456, 16'h0000, 2, 5, 1'b1);

        for (int i = 0; i < 20; i++)
            op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), addrs[$urandom_range(0, 3)],
               16'($urandom), 2, $urandom_range(1, 6), 1'b0);
        chk("enable_held_random", hold_err, 0);

        @(negedge clk);
        lag = 2; blen = 8;
        bus.p0_we = 1'b1; bus.p0_addr = 24'h000777; bus.p0_wdata = 16'hDEAD; bus.p0_req = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(bus.ctl_busy && !(bus.ctl_rd_enable || bus.ctl_wr_enable)) && cyc < 100);
        chk("reached_wait", cyc < 100, 1);
        rst = 1'b1;
        bus.p0_req = 1'b0;
        @(negedge clk);
        check_reset_state("midreset");
        rst = 1'b0;
        ref_rd0 = 16'h0;
        ref_rd1 = 16'h0;
        op(1'b0, 1'b0, 24'h000777, 16'h0000, 2, 3, 1'b0);
        op(1'b1, 1'b0, 24'h000123, 16'h0000, 2, 2, 1'b0);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ref_rd0 = 16'h0;
        ref_rd1 = 16'h0;
        lag = 2; blen = 3;
        bus.p0_we = 1'b0; bus.p0_addr = 24'h000123; bus.p0_req = 1'b1;
        bus.p1_we = 1'b0; bus.p1_addr = 24'h000456; bus.p1_req = 1'b1;
        n = 0;
        cyc = 0;
        while (n < 4 && cyc < 600) begin
            @(negedge clk);
            cyc++;
            if (bus.p0_ack) order[n++] = 1'b0;
            else if (bus.p1_ack) order[n++] = 1'b1;
        end
        bus.p0_req = 1'b0;
        bus.p1_req = 1'b0;
        chk("conflict_grants", n, 4);
        last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_w = RR ? !last : 1'b0;
            last = exp_w;
            chk($sformatf("conflict_grant%0d", i), order[i], exp_w);
        end
        chk("conflict_p0_rdata", bus.p0_rdata, mem_rd(24'h000123));
        chk("conflict_p1_rdata", bus.p1_rdata, RR ? mem_rd(24'h000456) : 16'h0);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
